csi2_packet_decoder: RTL and testbench

Lane-count-parametrised MIPI CSI-2 packet layer decoder. It sits after the per-lane byte aligners and runs in the byte clock domain. Each cycle it takes LANES aligned bytes, assembles and ECC-corrects packet headers, and decodes short packets into frame/line events. Long-packet payload is emitted as 32-bit words with a RAM write address, and the CRC-16 of every long packet is checked. It supersedes the fixed 2-lane, fixed-wordcount encoder/protocol pair.

---
 rtl/csi2_packet_decoder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_csi2_packet_decoder.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_packet_decoder.sv
// csi2_packet_decoder: CSI-2 packet layer, LANES bytes per byte clock.
// ECC-corrected headers, frame/line events, payload words and CRC-16 check.
module csi2_packet_decoder #(
  parameter int          LANES     = 2,
  parameter logic [5:0]  DT_FILTER = 6'h2A,
  parameter logic [15:0] MAX_WC    = 16'h1000,
  parameter int          ADDR_W    = 32
) (
  input  logic               mipi_clk,
  input  logic               reset,
  input  logic               stop,
  input  logic               byte_valid,
  input  logic [8*LANES-1:0] byte_in,
  output logic [31:0]        data_o,
  output logic               data_valid,
  output logic [ADDR_W-1:0]  address_o,
  output logic [5:0]         pkt_type,
  output logic [15:0]        wordcount,
  output logic [15:0]        line_cnt,
  output logic [15:0]        frame_cnt,
  output logic               frame_start,
  output logic               frame_end,
  output logic               ecc_corrected,
  output logic               ecc_error,
  output logic               len_error,
  output logic               crc_ok,
  output logic               crc_error,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CRC, DRAIN} state_t;

  function automatic logic [5:0] bit_syn(input logic [4:0] i);
    case (i)
      5'd0:  bit_syn = 6'h07;
      5'd1:  bit_syn = 6'h0B;
      5'd2:  bit_syn = 6'h0D;
      5'd3:  bit_syn = 6'h0E;
      5'd4:  bit_syn = 6'h13;
      5'd5:  bit_syn = 6'h15;
      5'd6:  bit_syn = 6'h16;
      5'd7:  bit_syn = 6'h19;
      5'd8:  bit_syn = 6'h1A;
      5'd9:  bit_syn = 6'h1C;
      5'd10: bit_syn = 6'h23;
      5'd11: bit_syn = 6'h25;
      5'd12: bit_syn = 6'h26;
      5'd13: bit_syn = 6'h29;
      5'd14: bit_syn = 6'h2A;
      5'd15: bit_syn = 6'h2C;
      5'd16: bit_syn = 6'h31;
      5'd17: bit_syn = 6'h32;
      5'd18: bit_syn = 6'h34;
      5'd19: bit_syn = 6'h38;
      5'd20: bit_syn = 6'h1F;
      5'd21: bit_syn = 6'h2F;
      5'd22: bit_syn = 6'h37;
      5'd23: bit_syn = 6'h3B;
      default: bit_syn = 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] ecc_calc(input logic [23:0] h);
    logic [5:0] e;
    e = '0;
    for (int i = 0; i < 24; i++)
      if (h[i]) e = e ^ bit_syn(5'(i));
    return e;
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                           input logic [7:0]  b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [23:0]         hdr_q, hdr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         plen_q, plen_d;
  logic [15:0]         crc_q, crc_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          wpos_q, wpos_d;
  logic [7:0]          rxlo_q, rxlo_d;
  logic                hit_q, hit_d;
  logic [31:0]         data_q, data_d;
  logic                dv_q, dv_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [5:0]          pkt_q, pkt_d;
  logic [15:0]         wc_q, wc_d;
  logic [15:0]         line_q, line_d;
  logic [15:0]         frame_q, frame_d;
  logic                fs_q, fs_d, fe_q, fe_d;
  logic                ecor_q, ecor_d, eerr_q, eerr_d;
  logic                lerr_q, lerr_d, cok_q, cok_d, cerr_q, cerr_d;
  logic [7:0]          b;
  logic [5:0]          syn;
  logic                found;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    crc_d   = crc_q;
    word_d  = word_q;
    wpos_d  = wpos_q;
    rxlo_d  = rxlo_q;
    hit_d   = hit_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, dv_q};
    pkt_d   = pkt_q;
    wc_d    = wc_q;
    line_d  = line_q;
    frame_d = frame_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    ecor_d  = 1'b0;
    eerr_d  = 1'b0;
    lerr_d  = 1'b0;
    cok_d   = 1'b0;
    cerr_d  = 1'b0;
    b       = '0;
    syn     = '0;
    found   = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (byte_valid) begin
      for (int i = 0; i < LANES; i++) begin
        b = byte_in[8*i +: 8];
        if (state_d == IDLE) begin
          state_d = HEADER;
          cnt_d   = '0;
        end
        unique case (state_d)
          HEADER: begin
            if (cnt_d[1:0] != 2'd3) begin
              hdr_d[8*cnt_d[1:0] +: 8] = b;
              cnt_d = cnt_d + 16'd1;
            end else begin
              syn   = ecc_calc(hdr_d) ^ b[5:0];
              found = 1'b0;
              for (int j = 0; j < 24; j++)
                if (syn != 6'h00 && bit_syn(5'(j)) == syn) begin
                  hdr_d[j] = ~hdr_d[j];
                  found    = 1'b1;
                end
              // a lone syndrome bit means the ECC byte itself was hit
              if (syn != 6'h00 && !found && !$onehot(syn)) begin
                eerr_d  = 1'b1;
                state_d = DRAIN;
              end else begin
                ecor_d = (syn != 6'h00);
                pkt_d  = hdr_d[5:0];
                wc_d   = hdr_d[23:8];
                hit_d  = (DT_FILTER == 6'h3F) || (hdr_d[5:0] == DT_FILTER);
                cnt_d  = '0;
                crc_d  = 16'hFFFF;
                word_d = '0;
                wpos_d = '0;
                plen_d = hdr_d[23:8];
                if (hdr_d[5:0] < 6'h10) begin
                  state_d = DRAIN;
                  if (hdr_d[5:0] == 6'h00) begin
                    fs_d    = 1'b1;
                    frame_d = frame_q + 16'd1;
                    line_d  = '0;
                    addr_d  = '0;
                  end
                  fe_d = (hdr_d[5:0] == 6'h01);
                end else if (hdr_d[23:8] == 16'h0000) begin
                  state_d = CRC;
                end else if (hdr_d[23:8] > MAX_WC) begin
                  lerr_d  = 1'b1;
                  state_d = DRAIN;
                end else begin
                  state_d = PAYLOAD;
                end
              end
            end
          end
          PAYLOAD: begin
            crc_d = crc_byte(crc_d, b);
            word_d[8*wpos_d +: 8] = b;
            wpos_d = wpos_d + 2'd1;
            cnt_d  = cnt_d + 16'd1;
            if (hit_d && (wpos_d == 2'd0 || cnt_d == plen_d)) begin
              dv_d   = 1'b1;
              data_d = word_d;
              word_d = '0;
              wpos_d = '0;
            end
            if (cnt_d == plen_d) begin
              state_d = CRC;
              cnt_d   = '0;
            end
          end
          CRC: begin
            if (cnt_d == 16'd0) begin
              rxlo_d = b;
              cnt_d  = 16'd1;
            end else begin
              if ({b, rxlo_d} == crc_d) begin
                cok_d = 1'b1;
                if (hit_d) line_d = line_d + 16'd1;
              end else begin
                cerr_d = 1'b1;
              end
              state_d = DRAIN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge mipi_clk) begin
    if (reset) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      cnt_q   <= '0;
      plen_q  <= '0;
      crc_q   <= '0;
      word_q  <= '0;
      wpos_q  <= '0;
      rxlo_q  <= '0;
      hit_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      addr_q  <= '0;
      pkt_q   <= '0;
      wc_q    <= '0;
      line_q  <= '0;
      frame_q <= '0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      ecor_q  <= 1'b0;
      eerr_q  <= 1'b0;
      lerr_q  <= 1'b0;
      cok_q   <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      crc_q   <= crc_d;
      word_q  <= word_d;
      wpos_q  <= wpos_d;
      rxlo_q  <= rxlo_d;
      hit_q   <= hit_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      addr_q  <= addr_d;
      pkt_q   <= pkt_d;
      wc_q    <= wc_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      ecor_q  <= ecor_d;
      eerr_q  <= eerr_d;
      lerr_q  <= lerr_d;
      cok_q   <= cok_d;
      cerr_q  <= cerr_d;
    end
  end

  assign data_o        = data_q;
  assign data_valid    = dv_q;
  assign address_o     = addr_q;
  assign pkt_type      = pkt_q;
  assign wordcount     = wc_q;
  assign line_cnt      = line_q;
  assign frame_cnt     = frame_q;
  assign frame_start   = fs_q;
  assign frame_end     = fe_q;
  assign ecc_corrected = ecor_q;
  assign ecc_error     = eerr_q;
  assign len_error     = lerr_q;
  assign crc_ok        = cok_q;
  assign crc_error     = cerr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// tb_csi2_packet_decoder: three decoders (LANES 1/2/4) on one clock,
// payload words checked against a queue of bench-predicted words.
module tb_csi2_packet_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        stp;
  logic        bv   [3];
  logic [31:0] bin  [3];
  logic [31:0] d_o  [3];
  logic        dv   [3];
  logic [31:0] ad   [3];
  logic [5:0]  pt   [3];
  logic [15:0] wc   [3];
  logic [15:0] lc   [3];
  logic [15:0] fc   [3];
  logic        fs   [3];
  logic        fe   [3];
  logic        ec   [3];
  logic        ee   [3];
  logic        le   [3];
  logic        cok  [3];
  logic        cerr [3];
  logic        bsy  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    csi2_packet_decoder #(.LANES(L)) u_dut (
      .mipi_clk      (clk),
      .reset         (rst),
      .stop          (stp),
      .byte_valid    (bv[g]),
      .byte_in       (bin[g][8*L-1:0]),
      .data_o        (d_o[g]),
      .data_valid    (dv[g]),
      .address_o     (ad[g]),
      .pkt_type      (pt[g]),
      .wordcount     (wc[g]),
      .line_cnt      (lc[g]),
      .frame_cnt     (fc[g]),
      .frame_start   (fs[g]),
      .frame_end     (fe[g]),
      .ecc_corrected (ec[g]),
      .ecc_error     (ee[g]),
      .len_error     (le[g]),
      .crc_ok        (cok[g]),
      .crc_error     (cerr[g]),
      .busy          (bsy[g])
    );
  end

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] pkt [$];
  logic [7:0] pl [$];
  logic [31:0] maddr [3];
  int total = 0;
  int bad = 0;
  int n_fs [3], n_fe [3], n_ec [3], n_ee [3];
  int n_le [3], n_cok [3], n_cerr [3], n_dv [3];

  function automatic int lanes(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] ecc_model(input logic [7:0] di,
                                           input logic [7:0] wl,
                                           input logic [7:0] wm);
    logic [23:0] d;
    logic [5:0]  p;
    d = {wm, wl, di};
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]
         ^ d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]
         ^ d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]
         ^ d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]
         ^ d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]
         ^ d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]
         ^ d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // byte-wise CCITT update in its reflected (0x8408) form
  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    logic [7:0]  x;
    c = 16'hFFFF;
    foreach (pl[i]) begin
      x = pl[i] ^ c[7:0];
      x = x ^ (x << 4);
      c = (c >> 8) ^ ({8'h00, x} << 8) ^ ({8'h00, x} << 3) ^ ({8'h00, x} >> 4);
    end
    return c;
  endfunction

  task automatic mk(input logic [7:0] di, input logic [7:0] wl,
                    input logic [7:0] wm, input logic [7:0] ecc,
                    input int n, input logic [7:0] base,
                    input logic [7:0] flip);
    logic [15:0] c;
    pkt = {di, wl, wm, ecc};
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'(base * (i + 1)));
    c = crc_model();
    foreach (pl[i]) pkt.push_back(pl[i]);
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8] ^ flip);
  endtask

  task automatic exp_words(input int k);
    logic [31:0] w;
    for (int i = 0; i < pl.size(); i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (i + j < pl.size()) w[8*j +: 8] = pl[i+j];
      sb.push_back('{k: 2'(k), a: maddr[k], d: w});
      maddr[k] = maddr[k] + 32'd1;
    end
  endtask

  task automatic drive(input int k, input bit abort);
    int n;
    int i;
    n = lanes(k);
    i = 0;
    while (i < pkt.size()) begin
      @(negedge clk);
      bin[k] = '0;
      if (abort && (pkt.size() - i) < n) begin
        bv[k] = 1'b0;
        stp = 1'b1;
      end else begin
        bv[k] = 1'b1;
        for (int j = 0; j < n; j++)
          if (i + j < pkt.size()) bin[k][8*j +: 8] = pkt[i+j];
      end
      i += n;
    end
    if (abort && !stp) begin
      @(negedge clk);
      bv[k] = 1'b0;
      stp = 1'b1;
    end
    @(negedge clk);
    bv[k] = 1'b0;
    stp = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stp = 1'b1;
    @(negedge clk);
    stp = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({d_o[1], dv[1], ad[1]} !== '0) begin
      bad++;
      $display("FAIL reset_data got d=%h v=%b a=%h want 0", d_o[1], dv[1], ad[1]);
    end
    total++;
    if ({pt[1], wc[1], lc[1], fc[1]} !== '0) begin
      bad++;
      $display("FAIL reset_hdr got pt=%h wc=%h lc=%h fc=%h want 0",
               pt[1], wc[1], lc[1], fc[1]);
    end
    total++;
    if ({fs[1], fe[1], ec[1], ee[1], le[1], cok[1], cerr[1], bsy[1]} !== '0) begin
      bad++;
      $display("FAIL reset_pulses got %b want 0",
               {fs[1], fe[1], ec[1], ee[1], le[1], cok[1], cerr[1], bsy[1]});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame();
    int s_fs, s_fe, s_ec, s_ee;
    s_fs = n_fs[1]; s_fe = n_fe[1]; s_ec = n_ec[1]; s_ee = n_ee[1];
    pkt = {8'h00, 8'h00, 8'h00, 8'h00};
    drive(1, 0);
    repeat (2) @(negedge clk);
    total++;
    if (n_fs[1] - s_fs !== 1) begin
      bad++;
      $display("FAIL fs_pulse got %0d want 1", n_fs[1] - s_fs);
    end
    total++;
    if (fc[1] !== 16'd1 || lc[1] !== 16'd0 || ad[1] !== 32'd0) begin
      bad++;
      $display("FAIL fs_counts got fc=%0d lc=%0d a=%0d want 1 0 0", fc[1], lc[1], ad[1]);
    end
    total++;
    if (bsy[1] !== 1'b1) begin
      bad++;
      $display("FAIL fs_drain got busy=%b want 1", bsy[1]);
    end
    do_stop();
    maddr[1] = 0;
    pkt = {8'h01, 8'h00, 8'h00, 8'h07};
    drive(1, 0);
    repeat (2) @(negedge clk);
    total++;
    if (n_fe[1] - s_fe !== 1 || n_fs[1] - s_fs !== 1) begin
      bad++;
      $display("FAIL fe_pulse got fe=%0d fs=%0d want 1 1", n_fe[1] - s_fe, n_fs[1] - s_fs);
    end
    total++;
    if (n_ec[1] - s_ec !== 0 || n_ee[1] - s_ee !== 0) begin
      bad++;
      $display("FAIL fe_ecc got corr=%0d err=%0d want 0 0", n_ec[1] - s_ec, n_ee[1] - s_ee);
    end
    total++;
    if (pt[1] !== 6'h01 || fc[1] !== 16'd1) begin
      bad++;
      $display("FAIL fe_state got pt=%h fc=%0d want 01 1", pt[1], fc[1]);
    end
    do_stop();
  endtask

  task automatic test_long(input logic [7:0] flip, input logic [15:0] lc_want);
    int s_ok, s_err, s_dv;
    s_ok = n_cok[1]; s_err = n_cerr[1]; s_dv = n_dv[1];
    mk(8'h2A, 8'h04, 8'h00, 8'h33, 4, 8'h11, flip);
    exp_words(1);
    drive(1, 0);
    repeat (3) @(negedge clk);
    total++;
    if (n_dv[1] - s_dv !== 1) begin
      bad++;
      $display("FAIL long_words got %0d want 1", n_dv[1] - s_dv);
    end
    total++;
    if (n_cok[1] - s_ok !== int'(flip == 0) || n_cerr[1] - s_err !== int'(flip != 0)) begin
      bad++;
      $display("FAIL long_crc got ok=%0d err=%0d want %0d %0d",
               n_cok[1] - s_ok, n_cerr[1] - s_err, flip == 0, flip != 0);
    end
    total++;
    if (lc[1] !== lc_want || pt[1] !== 6'h2A || wc[1] !== 16'd4) begin
      bad++;
      $display("FAIL long_hdr got lc=%0d pt=%h wc=%0d want %0d 2a 4",
               lc[1], pt[1], wc[1], lc_want);
    end
    do_stop();
  endtask

  task automatic test_ecc();
    int s_ec, s_ee, s_dv;
    s_ec = n_ec[1]; s_ee = n_ee[1]; s_dv = n_dv[1];
    pkt = {8'h01, 8'h00, 8'h00, 8'h07};
    drive(1, 0);
    do_stop();
    mk(8'h2B, 8'h04, 8'h00, 8'h33, 4, 8'h11, 8'h00);
    exp_words(1);
    drive(1, 0);
    repeat (3) @(negedge clk);
    total++;
    if (n_ec[1] - s_ec !== 1 || pt[1] !== 6'h2A) begin
      bad++;
      $display("FAIL ecc_fix got corr=%0d pt=%h want 1 2a", n_ec[1] - s_ec, pt[1]);
    end
    total++;
    if (n_dv[1] - s_dv !== 1 || lc[1] !== 16'd2) begin
      bad++;
      $display("FAIL ecc_fix_data got words=%0d lc=%0d want 1 2", n_dv[1] - s_dv, lc[1]);
    end
    do_stop();
    mk(8'h29, 8'h04, 8'h00, 8'h33, 4, 8'h11, 8'h00);
    drive(1, 0);
    repeat (3) @(negedge clk);
    total++;
    if (n_ee[1] - s_ee !== 1 || n_dv[1] - s_dv !== 1) begin
      bad++;
      $display("FAIL ecc_err got err=%0d words=%0d want 1 1", n_ee[1] - s_ee, n_dv[1] - s_dv);
    end
    total++;
    if (bsy[1] !== 1'b1 || pt[1] !== 6'h2A) begin
      bad++;
      $display("FAIL ecc_err_state got busy=%b pt=%h want 1 2a", bsy[1], pt[1]);
    end
    do_stop();
    total++;
    if (bsy[1] !== 1'b0) begin
      bad++;
      $display("FAIL ecc_err_stop got busy=%b want 0", bsy[1]);
    end
  endtask

  task automatic test_sweep();
    int s_ok, s_err, s_dv;
    logic [7:0] e;
    e = ecc_model(8'h2A, 8'h06, 8'h00);
    for (int k = 0; k < 3; k++) begin
      pkt = {8'h00, 8'h00, 8'h00, 8'h00};
      drive(k, 0);
      do_stop();
      maddr[k] = 0;
      s_ok = n_cok[k]; s_err = n_cerr[k]; s_dv = n_dv[k];
      mk(8'h2A, 8'h06, 8'h00, e, 6, 8'h01, 8'h00);
      exp_words(k);
      drive(k, 0);
      repeat (3) @(negedge clk);
      total++;
      if (n_dv[k] - s_dv !== 2 || n_cok[k] - s_ok !== 1 || n_cerr[k] - s_err !== 0) begin
        bad++;
        $display("FAIL sweep_l%0d got words=%0d ok=%0d err=%0d want 2 1 0",
                 lanes(k), n_dv[k] - s_dv, n_cok[k] - s_ok, n_cerr[k] - s_err);
      end
      total++;
      if (lc[k] !== 16'd1 || wc[k] !== 16'd6) begin
        bad++;
        $display("FAIL sweep_l%0d_hdr got lc=%0d wc=%0d want 1 6", lanes(k), lc[k], wc[k]);
      end
      do_stop();
      s_ok = n_cok[k]; s_err = n_cerr[k]; s_dv = n_dv[k];
      mk(8'h2A, 8'h06, 8'h00, e, 6, 8'h01, 8'h00);
      pkt = pkt[0:6];
      drive(k, 1);
      total++;
      if (bsy[k] !== 1'b0) begin
        bad++;
        $display("FAIL abort_l%0d_idle got busy=%b want 0", lanes(k), bsy[k]);
      end
      repeat (3) @(negedge clk);
      total++;
      if (n_dv[k] - s_dv !== 0 || n_cok[k] - s_ok !== 0 || n_cerr[k] - s_err !== 0) begin
        bad++;
        $display("FAIL abort_l%0d got words=%0d ok=%0d err=%0d want 0 0 0",
                 lanes(k), n_dv[k] - s_dv, n_cok[k] - s_ok, n_cerr[k] - s_err);
      end
    end
  endtask

  task automatic test_len();
    int s_le, s_dv;
    s_le = n_le[1]; s_dv = n_dv[1];
    mk(8'h2A, 8'h00, 8'h20, ecc_model(8'h2A, 8'h00, 8'h20), 8, 8'h05, 8'h00);
    drive(1, 0);
    repeat (2) @(negedge clk);
    total++;
    if (n_le[1] - s_le !== 1 || n_dv[1] - s_dv !== 0) begin
      bad++;
      $display("FAIL len got err=%0d words=%0d want 1 0", n_le[1] - s_le, n_dv[1] - s_dv);
    end
    total++;
    if (bsy[1] !== 1'b1) begin
      bad++;
      $display("FAIL len_drain got busy=%b want 1", bsy[1]);
    end
    do_stop();
  endtask

  task automatic test_reset_mid();
    mk(8'h2A, 8'h08, 8'h00, ecc_model(8'h2A, 8'h08, 8'h00), 8, 8'h03, 8'h00);
    pkt = pkt[0:5];
    drive(1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({d_o[1], dv[1], ad[1], pt[1], wc[1]} !== '0) begin
      bad++;
      $display("FAIL rst_mid_data got d=%h a=%h pt=%h wc=%h want 0",
               d_o[1], ad[1], pt[1], wc[1]);
    end
    total++;
    if ({lc[1], fc[1], bsy[1]} !== '0) begin
      bad++;
      $display("FAIL rst_mid_cnt got lc=%0d fc=%0d busy=%b want 0", lc[1], fc[1], bsy[1]);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) maddr[k] = 0;
    repeat (3) @(negedge clk);
    total++;
    if (dv[1] !== 1'b0 || bsy[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_after got dv=%b busy=%b want 0 0", dv[1], bsy[1]);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    stp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bv[k] = 1'b0;
      bin[k] = '0;
      maddr[k] = 0;
      n_fs[k] = 0; n_fe[k] = 0; n_ec[k] = 0; n_ee[k] = 0;
      n_le[k] = 0; n_cok[k] = 0; n_cerr[k] = 0; n_dv[k] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (fs[k] === 1'b1) n_fs[k]++;
          if (fe[k] === 1'b1) n_fe[k]++;
          if (ec[k] === 1'b1) n_ec[k]++;
          if (ee[k] === 1'b1) n_ee[k]++;
          if (le[k] === 1'b1) n_le[k]++;
          if (cok[k] === 1'b1) n_cok[k]++;
          if (cerr[k] === 1'b1) n_cerr[k]++;
          if (dv[k] === 1'b1) begin
            n_dv[k]++;
            total++;
            if (sb.size() == 0) begin
              bad++;
              $display("FAIL word_l%0d got %h@%0d want none", lanes(k), d_o[k], ad[k]);
            end else begin
              e = sb.pop_front();
              if (e.k !== 2'(k) || e.d !== d_o[k] || e.a !== ad[k]) begin
                bad++;
                $display("FAIL word_l%0d got %h@%0d want %h@%0d (lanes idx %0d)",
                         lanes(k), d_o[k], ad[k], e.d, e.a, e.k);
              end
            end
          end
        end
      end
    join_none
    test_reset();
    test_frame();
    test_long(8'h00, 16'd1);
    test_long(8'h01, 16'd1);
    test_ecc();
    test_sweep();
    test_len();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL words_left got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
